// File: rtl/uart_rx_ext.sv
// -----------------------------------------------------------------------------
// uart_rx_ext
//
// Parametrised UART receiver that sits between the board RX pin and the
// command/packet parser. It is the successor to the fixed 8N1 receiver.
//
// What it does:
//   - Synchronises the asynchronous rx pin through SYNC_STAGES flops.
//   - Detects a start bit as a falling edge of the synchronised line in IDLE.
//   - Times each bit with a runtime baud divisor and samples it in mid-bit.
//   - Rejects false starts: the start bit must still be low at mid-bit.
//   - Receives DATA_W data bits (LSB first), an optional even/odd parity bit
//     and STOP_BITS stop bits.
//   - Flags each byte with frame (bad stop bit) and parity errors.
//   - Buffers received bytes in an output FIFO read through valid/ready.
//
// Parameters:
//   DATA_W      data bits per frame, 5..9
//   STOP_BITS   stop bits checked, 1 or 2
//   SYNC_STAGES rx synchroniser depth, >= 2
//   FIFO_DEPTH  output FIFO entries, power of two, >= 2
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   baud_div    clocks per bit; values below 2 behave as 2
//   parity_en   1 = a parity bit follows the data bits
//   parity_odd  1 = odd parity, 0 = even parity
//   rx          serial input, idle high
//   data_out    data of the FIFO head entry
//   frame_err   head entry had a bad stop bit
//   parity_err  head entry had a parity mismatch
//   data_valid  FIFO not empty
//   data_ready  consumer accepts the head entry
//   overrun     one-cycle pulse: a received frame was lost, FIFO full
//   busy        receive FSM is not in IDLE
//   dbg_state   current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Output handshake: the head entry (data_out, frame_err, parity_err) is
// offered while data_valid=1 and is held stable until it is popped; a pop
// happens on every rising clk edge where data_valid && data_ready. There is
// no fall-through: a byte pushed into an empty FIFO is presented on the
// cycle after the push and can be popped at the earliest one edge later.
// -----------------------------------------------------------------------------
module uart_rx_ext #(
    parameter int DATA_W      = 8,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       baud_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_err,
    output logic              parity_err,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 2;

    localparam logic [3:0]       LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser and start-edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic                   start;

    // Flops reset to 1 so that a line held idle-high never looks like a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Edge based: a stop bit that was received low cannot retrigger a frame
    // until the line has been seen high again.
    assign start = rx_prev_q && !rx_s;

    // -------------------------------------------------------------------------
    // Receive FSM with bit timer
    // -------------------------------------------------------------------------
    state_t              state_q;
    logic [31:0]         cnt_q;
    logic [31:0]         div_q;
    logic                par_en_q;
    logic                par_odd_q;
    logic [DATA_W-1:0]   shift_q;
    logic [3:0]          bit_idx_q;
    logic                ferr_q;
    logic                perr_q;
    logic                push_q;
    logic [31:0]         div_eff;

    assign div_eff = (baud_div < 32'd2) ? 32'd2 : baud_div;

    // The timer is loaded with half a bit on the start edge so the first
    // sample lands mid start-bit; after every sample it reloads a full bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 32'd2;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Configuration is frozen for the whole frame.
                        div_q     <= div_eff;
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_odd;
                        cnt_q     <= (div_eff >> 1) - 32'd1;
                        bit_idx_q <= '0;
                        ferr_q    <= 1'b0;
                        perr_q    <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                default: begin
                    if (cnt_q != 32'd0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else begin
                        cnt_q <= div_q - 32'd1;
                        case (state_q)
                            S_START: begin
                                if (rx_s) begin
                                    // Glitch shorter than half a bit.
                                    state_q <= S_IDLE;
                                end else begin
                                    bit_idx_q <= '0;
                                    state_q   <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                // Shift in from the top: after DATA_W samples
                                // the first bit received sits in bit 0.
                                shift_q <= {rx_s, shift_q[DATA_W-1:1]};
                                if (bit_idx_q == LAST_DATA) begin
                                    bit_idx_q <= '0;
                                    state_q   <= par_en_q ? S_PARITY : S_STOP;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 4'd1;
                                end
                            end
                            S_PARITY: begin
                                // 1 = mismatch for the selected parity sense.
                                perr_q  <= (^shift_q) ^ rx_s ^ par_odd_q;
                                state_q <= S_STOP;
                            end
                            S_STOP: begin
                                if (!rx_s) begin
                                    ferr_q <= 1'b1;
                                end
                                if (bit_idx_q == LAST_STOP) begin
                                    push_q  <= 1'b1;
                                    state_q <= S_IDLE;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 4'd1;
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   remain;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] head_d;
    logic               data_valid_q;
    logic               overrun_q;
    logic               overrun_d;
    logic               full;
    logic               do_pop;
    logic               do_push;

    assign entry_in = {shift_q, ferr_q, perr_q};
    assign full     = (count_q == FULL_CNT);
    assign do_pop   = data_valid_q && data_ready;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // only drops the frame when nothing is leaving.
    assign do_push   = push_q && (!full || do_pop);
    assign overrun_d = push_q && full && !do_pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        remain   = count_q - CNT_W'(do_pop);
        // If nothing older survives this cycle, the next head can only be
        // the entry being written now; otherwise it already sits in memory.
        if (remain == '0) begin
            head_d = entry_in;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_valid_q <= (count_d != '0);
            overrun_q    <= overrun_d;
            // Head view only moves when there is a new head to show, so it
            // stays stable while the consumer is stalling.
            if (count_d != '0) begin
                head_q <= head_d;
            end
        end
    end

    assign data_out   = head_q[ENTRY_W-1:2];
    assign frame_err  = head_q[1];
    assign parity_err = head_q[0];
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;

endmodule
